// File: rtl/ym_phase_seq_if.sv
// ym_phase_seq_if -- handshake/bus bundle between the phase sequencer and
// the c1/c2 cells it drives.
//
// Signals:
//   en        run request, level-sensitive
//   restart   single-MCLK pulse, forces slot to 0 at the next slot boundary
//   dbg_req   single-MCLK pulse, requests a debug snapshot load
//   c1, c2    non-overlapping phase enables
//   slot      current slot index
//   slot_last high while slot is the final slot of the frame
//   sync      frame-start pulse
//   dbg_load  parallel-load enable for the debug chains
//   dbg_busy  debug load in progress or chain still shifting out
//
// Modports:
//   master  the side that issues requests and consumes the phase outputs
//   slave   the sequencer itself
interface ym_phase_seq_if #(
  parameter int SLOT_W = 5
);
  logic              en;
  logic              restart;
  logic              dbg_req;
  logic              c1;
  logic              c2;
  logic [SLOT_W-1:0] slot;
  logic              slot_last;
  logic              sync;
  logic              dbg_load;
  logic              dbg_busy;

  modport master (
    output en, restart, dbg_req,
    input  c1, c2, slot, slot_last, sync, dbg_load, dbg_busy
  );

  modport slave (
    input  en, restart, dbg_req,
    output c1, c2, slot, slot_last, sync, dbg_load, dbg_busy
  );
endinterface

// File: rtl/ym_phase_seq.sv
// ym_phase_seq -- two-phase clock and slot sequencer.
//
// Divides MCLK into non-overlapping c1/c2 phase enables, counts the slot
// index every slot-serial datapath is aligned to, emits a frame sync and
// schedules the parallel-load strobe for the debug read-out chains.
//
// Parameters:
//   DIV      MCLK cycles per half phase (2..16)
//   SLOTS    slots per frame (2..32)
//   SLOT_W   slot counter width, 2**SLOT_W >= SLOTS
//   DBG_LEN  slot cycles the debug chain shifts after a load (1..SLOTS)
//
// Ports:
//   MCLK   master clock, all state updates on its rising edge
//   reset  synchronous, active-high reset
//   bus    ym_phase_seq_if.slave: en/restart/dbg_req in, phase/slot/debug out
module ym_phase_seq #(
  parameter int DIV     = 3,
  parameter int SLOTS   = 24,
  parameter int SLOT_W  = 5,
  parameter int DBG_LEN = 8
) (
  input  logic           MCLK,
  input  logic           reset,
  ym_phase_seq_if.slave  bus
);

  localparam int PH_W  = $clog2(2 * DIV);
  localparam int CNT_W = $clog2(DBG_LEN + 1);

  // Phase decode points within one 2*DIV slot cycle.
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(2 * DIV - 1);
  localparam logic [PH_W-1:0]   PH_C1_END = PH_W'(DIV - 2);
  localparam logic [PH_W-1:0]   PH_C2_BEG = PH_W'(DIV);
  localparam logic [PH_W-1:0]   PH_C2_END = PH_W'(2 * DIV - 2);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);
  localparam logic [CNT_W-1:0]  DBG_FULL  = CNT_W'(DBG_LEN);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state;
  logic [PH_W-1:0]   ph;
  logic [SLOT_W-1:0] slot;
  logic              restart_pend;
  logic              dbg_pend;
  // Slot cycles of debug activity still to run; nonzero means busy.
  logic [CNT_W-1:0]  dbg_cnt;

  logic              running;
  logic              boundary;
  logic [SLOT_W-1:0] slot_next;
  logic              dbg_start;
  logic              c1_dec;

  // NOTE: every variable here is assigned on every pass through the block,
  // so it stays pure combinational logic and no latch is inferred.
  always_comb begin
    running   = (state == ST_RUN);
    boundary  = running && (ph == PH_LAST);
    slot_next = (restart_pend || slot == SLOT_LAST) ? '0 : slot + SLOT_W'(1);
    // A snapshot may only begin as a new frame starts and the chain is free.
    dbg_start = boundary && (slot_next == '0) && dbg_pend && (dbg_cnt == '0);
    c1_dec    = running && (ph <= PH_C1_END);
  end

  // NOTE: reset is sampled on the clock edge (synchronous), and all state
  // registers use non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      state        <= ST_IDLE;
      ph           <= '0;
      slot         <= '0;
      restart_pend <= 1'b0;
      dbg_pend     <= 1'b0;
      dbg_cnt      <= '0;
    end else begin
      // A request arriving on the consuming edge itself stays pending.
      restart_pend <= bus.restart | (restart_pend & ~boundary);
      dbg_pend     <= bus.dbg_req | (dbg_pend & ~dbg_start);

      if (state == ST_IDLE) begin
        ph <= '0;
        if (bus.en) state <= ST_RUN;
      end else if (boundary) begin
        // The current slot cycle always completes; en only matters here.
        ph   <= '0;
        slot <= slot_next;
        if (!bus.en) state <= ST_IDLE;
      end else begin
        ph <= ph + PH_W'(1);
      end

      // Counting freezes while idle because no boundary occurs there.
      if (dbg_start) begin
        dbg_cnt <= DBG_FULL;
      end else if (boundary && dbg_cnt != '0) begin
        dbg_cnt <= dbg_cnt - CNT_W'(1);
      end
    end
  end

  assign bus.c1        = c1_dec;
  assign bus.c2        = running && (ph >= PH_C2_BEG) && (ph <= PH_C2_END);
  assign bus.slot      = slot;
  assign bus.slot_last = (slot == SLOT_LAST);
  assign bus.sync      = running && (ph == '0) && (slot == '0);
  // The counter holds its full value only during the first slot of a load.
  assign bus.dbg_load  = c1_dec && (dbg_cnt == DBG_FULL);
  assign bus.dbg_busy  = (dbg_cnt != '0);

endmodule

// File: tb/tb_ym_phase_seq.sv
// tb_ym_phase_seq -- self-checking bench for ym_phase_seq.
//
// A reference model tracks run state, phase position, slot index, pending
// requests and the remaining debug activity measured in running MCLK cycles.
// Every clock the DUT outputs are compared with the model; table vectors and
// hand-written sequences add constant expectations for the corner cases.
module tb_ym_phase_seq;

  localparam int DIV     = 3;
  localparam int SLOTS   = 24;
  localparam int SLOT_W  = 5;
  localparam int DBG_LEN = 8;

  logic MCLK  = 1'b0;
  logic reset = 1'b1;

  ym_phase_seq_if #(.SLOT_W(SLOT_W)) bus ();

  ym_phase_seq #(
    .DIV(DIV), .SLOTS(SLOTS), .SLOT_W(SLOT_W), .DBG_LEN(DBG_LEN)
  ) dut (
    .MCLK (MCLK),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 MCLK = ~MCLK;

  int n_pass    = 0;
  int n_checks  = 0;
  int n_overlap = 0;

  // Reference model state.
  bit m_run      = 1'b0;
  bit m_rst_pend = 1'b0;
  bit m_dbg_pend = 1'b0;
  int m_ph       = 0;
  int m_slot     = 0;
  int m_busy_left = 0;  // running MCLK cycles of debug activity remaining

  typedef struct {
    bit rst;
    bit en;
    bit c1;
    bit c2;
    bit sync;
    int slot;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic model_edge(input bit rst, input bit en, input bit rs, input bit dr);
    bit bnd;
    bit was_busy;
    int nxt;
    if (rst) begin
      m_run = 0; m_ph = 0; m_slot = 0;
      m_rst_pend = 0; m_dbg_pend = 0; m_busy_left = 0;
      return;
    end
    bnd      = m_run && (m_ph == 2 * DIV - 1);
    was_busy = (m_busy_left > 0);
    if (m_run && was_busy) m_busy_left--;
    if (bnd) begin
      nxt = (m_rst_pend || m_slot == SLOTS - 1) ? 0 : m_slot + 1;
      if (nxt == 0 && m_dbg_pend && !was_busy) begin
        m_busy_left = DBG_LEN * 2 * DIV;
        m_dbg_pend  = 0;
      end
      m_slot = nxt;
      m_ph = 0;
      m_rst_pend = 0;
      if (!en) m_run = 0;
    end else if (m_run) begin
      m_ph++;
    end else if (en) begin
      m_run = 1;
    end
    if (rs) m_rst_pend = 1;
    if (dr) m_dbg_pend = 1;
  endtask

  task automatic check_all();
    bit e_c1;
    bit e_c2;
    bit e_sync;
    bit e_load;
    e_c1   = m_run && (m_ph <= DIV - 2);
    e_c2   = m_run && (m_ph >= DIV) && (m_ph <= 2 * DIV - 2);
    e_sync = m_run && (m_ph == 0) && (m_slot == 0);
    e_load = e_c1 && (m_busy_left > (DBG_LEN - 1) * 2 * DIV);
    check("c1", int'(bus.c1), int'(e_c1));
    check("c2", int'(bus.c2), int'(e_c2));
    check("slot", int'(bus.slot), m_slot);
    check("slot_last", int'(bus.slot_last), int'(m_slot == SLOTS - 1));
    check("sync", int'(bus.sync), int'(e_sync));
    check("dbg_load", int'(bus.dbg_load), int'(e_load));
    check("dbg_busy", int'(bus.dbg_busy), int'(m_busy_left > 0));
    if (bus.c1 && bus.c2) n_overlap++;
  endtask

  task automatic tick(input bit rst, input bit en, input bit rs, input bit dr);
    reset       = rst;
    bus.en      = en;
    bus.restart = rs;
    bus.dbg_req = dr;
    @(posedge MCLK);
    model_edge(rst, en, rs, dr);
    #1;
    check_all();
  endtask

  // Run with en held until the model sits at the requested slot/phase.
  task automatic goto(input int s, input int p);
    int n;
    n = 0;
    while (!(m_run && m_slot == s && m_ph == p) && n < 400) begin
      tick(0, 1, 0, 0);
      n++;
    end
    check($sformatf("goto_slot%0d", s), int'(bus.slot), s);
  endtask

  task automatic wait_sync(input string name);
    int n;
    n = 0;
    do begin
      tick(0, 1, 0, 0);
      n++;
    end while (!bus.sync && n < 400);
    check(name, int'(bus.sync), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, sl, mx, b, l, s;
    bus.en      = 1'b0;
    bus.restart = 1'b0;
    bus.dbg_req = 1'b0;

    // Reset, one idle cycle, then the first phase pattern with en held.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1};

    foreach (vecs[i]) begin
      tick(vecs[i].rst, vecs[i].en, 0, 0);
      check($sformatf("vec%0d_c1", i), int'(bus.c1), int'(vecs[i].c1));
      check($sformatf("vec%0d_c2", i), int'(bus.c2), int'(vecs[i].c2));
      check($sformatf("vec%0d_sync", i), int'(bus.sync), int'(vecs[i].sync));
      check($sformatf("vec%0d_slot", i), int'(bus.slot), vecs[i].slot);
    end

    // Two free-running frames: period, slot_last width, slot range.
    wait_sync("sync_first");
    for (int f = 0; f < 2; f++) begin
      n = 0; sl = 0; mx = 0;
      while (n < 400) begin
        tick(0, 1, 0, 0);
        n++;
        if (bus.slot_last) sl++;
        if (int'(bus.slot) > mx) mx = int'(bus.slot);
        if (bus.sync) break;
      end
      check("frame_period", n, 2 * DIV * SLOTS);
      check("slot_last_cycles", sl, 2 * DIV);
      check("max_slot", mx, SLOTS - 1);
    end

    // Restart mid-frame at slot 7, ph 2.
    goto(7, 2);
    tick(0, 1, 1, 0);
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    check("restart_hold_slot", int'(bus.slot), 7);
    tick(0, 1, 0, 0);
    check("restart_slot0", int'(bus.slot), 0);
    check("restart_sync", int'(bus.sync), 1);

    // Restart coinciding with the natural wrap.
    goto(23, 4);
    tick(0, 1, 1, 0);
    tick(0, 1, 0, 0);
    check("restart_wrap_slot0", int'(bus.slot), 0);
    check("restart_wrap_sync", int'(bus.sync), 1);
    repeat (2 * DIV) tick(0, 1, 0, 0);
    check("restart_wrap_next", int'(bus.slot), 1);

    // Drop en at slot 5, ph 1: the slot cycle completes, then park.
    goto(5, 1);
    repeat (4) tick(0, 0, 0, 0);
    check("stop_finish_slot", int'(bus.slot), 5);
    tick(0, 0, 0, 0);
    check("stop_c1", int'(bus.c1), 0);
    check("stop_c2", int'(bus.c2), 0);
    check("stop_slot", int'(bus.slot), 6);
    repeat (3) tick(0, 0, 0, 0);
    check("idle_c1", int'(bus.c1), 0);
    tick(0, 1, 0, 0);
    check("resume_c1", int'(bus.c1), 1);
    check("resume_slot", int'(bus.slot), 6);

    // Debug snapshot requested at slot 10, a second one during busy.
    goto(10, 0);
    tick(0, 1, 0, 1);
    wait_sync("dbg_sync");
    check("dbg_load_at_sync", int'(bus.dbg_load), 1);
    b = 1; l = 1; n = 0;
    while (bus.dbg_busy && n < 200) begin
      tick(0, 1, 0, n == 10);
      n++;
      if (bus.dbg_busy) b++;
      if (bus.dbg_load) l++;
    end
    check("dbg_busy_len", b, DBG_LEN * 2 * DIV);
    check("dbg_load_len", l, DIV - 1);
    wait_sync("dbg_sync2");
    check("dbg_second_load", int'(bus.dbg_load), 1);

    // Reset at slot 3, ph 4 while busy; no load afterwards without a request.
    goto(3, 4);
    check("rst_busy_before", int'(bus.dbg_busy), 1);
    tick(1, 1, 0, 0);
    check("rst_slot", int'(bus.slot), 0);
    check("rst_c2", int'(bus.c2), 0);
    check("rst_busy", int'(bus.dbg_busy), 0);
    tick(1, 1, 0, 1);
    check("rst_req_ignored", int'(bus.dbg_busy), 0);
    l = 0; s = 0;
    for (int i = 0; i < 320; i++) begin
      tick(0, 1, 0, 0);
      if (bus.dbg_load) l++;
      if (bus.sync) s++;
    end
    check("post_reset_loads", l, 0);
    check("post_reset_syncs", s, 3);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      tick($urandom_range(0, 999) == 0,
           $urandom_range(0, 19) != 0,
           $urandom_range(0, 49) == 0,
           $urandom_range(0, 29) == 0);
    end

    check("c1_c2_overlap", n_overlap, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
